// File: rtl/cmlk_frame_stat_collector.sv
// cmlk_frame_stat_collector
//   Per-frame statistics collector in the clk_100m timing domain. Rising edges of the CMOS
//   trigger delimit frames. Within a frame it counts laser pulses, gate pulses and gate-on
//   cycles. One record per completed frame is queued in a first-word-fall-through FIFO.
//
//   Optional build macro CMLK_STAT_TIMESTAMP_EN: appends a 32-bit cycle timestamp, latched at
//   each frame's opening trigger edge, at the LSB end of the record.
//
// Ports
//   clk, rst          timing clock; asynchronous active-high reset
//   stat_en           collection enable (low drops any partial frame)
//   stat_clear        pulse; clears overflow and drop_cnt
//   cmos_trig_pulse   trigger level; its rising edge opens and closes frames
//   laser_act         laser activity (OR of serializer word)
//   gate_act          gate activity (OR of serializer word)
//   frame_type        01 = A, 10 = B, 00 = background
//   stat_valid        FIFO head record valid
//   stat_ready        consumer accepts head record
//   stat_data         {frame_type, frame_idx, laser_cnt, gate_cnt, gate_on[, timestamp]}
//   fifo_level        occupied FIFO entries
//   overflow          sticky record-dropped flag
//   drop_cnt          dropped records, saturating
module cmlk_frame_stat_collector #(
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned CNT_W      = 16,
    localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1,
`ifdef CMLK_STAT_TIMESTAMP_EN
    localparam int unsigned REC_W     = 82 + 2 * CNT_W
`else
    localparam int unsigned REC_W     = 50 + 2 * CNT_W
`endif
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stat_en,
    input  logic             stat_clear,
    input  logic             cmos_trig_pulse,
    input  logic             laser_act,
    input  logic             gate_act,
    input  logic [1:0]       frame_type,
    output logic             stat_valid,
    input  logic             stat_ready,
    output logic [REC_W-1:0] stat_data,
    output logic [LVL_W-1:0] fifo_level,
    output logic             overflow,
    output logic [15:0]      drop_cnt
);

    localparam int unsigned      AW       = LVL_W - 1;
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(FIFO_DEPTH);

    // ---------------- edge detection ----------------
    logic       trig_prev, laser_prev, gate_prev;
    logic       trig_rise, laser_rise, gate_rise;
    logic [1:0] ft_prev;  // frame_type of the previous cycle

    assign trig_rise  = cmos_trig_pulse & ~trig_prev;
    assign laser_rise = laser_act & ~laser_prev;
    assign gate_rise  = gate_act & ~gate_prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            trig_prev  <= 1'b0;
            laser_prev <= 1'b0;
            gate_prev  <= 1'b0;
            ft_prev    <= 2'b00;
        end else begin
            trig_prev  <= cmos_trig_pulse;
            laser_prev <= laser_act;
            gate_prev  <= gate_act;
            ft_prev    <= frame_type;
        end
    end

    // ---------------- frame FSM ----------------
    typedef enum logic [1:0] {StIdle, StAcq, StCommit} state_e;
    state_e state_q, state_d;
    logic   cnt_load, cnt_run, snap, push;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // A trigger edge cannot land in StCommit: it needs a low cycle after the closing edge.
    always_comb begin
        state_d  = state_q;
        cnt_load = 1'b0;
        cnt_run  = 1'b0;
        snap     = 1'b0;
        push     = 1'b0;
        case (state_q)
            StIdle: begin
                if (stat_en && trig_rise) begin
                    cnt_load = 1'b1;
                    state_d  = StAcq;
                end
            end
            StAcq: begin
                if (trig_rise) begin
                    snap     = 1'b1;
                    cnt_load = 1'b1;
                    state_d  = StCommit;
                end else begin
                    cnt_run = 1'b1;
                end
            end
            StCommit: begin
                push    = 1'b1;
                cnt_run = 1'b1;
                state_d = StAcq;
            end
            default: state_d = StIdle;
        endcase
        if (!stat_en) state_d = StIdle;
    end

    // ---------------- per-frame counters ----------------
    logic [CNT_W-1:0] laser_cnt, gate_cnt;
    logic [31:0]      gate_on;

    // A load takes the events of the edge cycle itself: that cycle opens the new frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            laser_cnt <= '0;
            gate_cnt  <= '0;
            gate_on   <= '0;
        end else if (cnt_load) begin
            laser_cnt <= CNT_W'(laser_rise);
            gate_cnt  <= CNT_W'(gate_rise);
            gate_on   <= 32'(gate_act);
        end else if (cnt_run) begin
            if (laser_rise && (laser_cnt != '1)) laser_cnt <= laser_cnt + CNT_W'(1);
            if (gate_rise && (gate_cnt != '1))   gate_cnt  <= gate_cnt + CNT_W'(1);
            if (gate_act && (gate_on != '1))     gate_on   <= gate_on + 32'd1;
        end else if (state_q == StIdle) begin
            laser_cnt <= '0;
            gate_cnt  <= '0;
            gate_on   <= '0;
        end
    end

    // ---------------- record snapshot ----------------
    logic [15:0]      frame_idx;
    logic [REC_W-1:0] rec_d, rec_q;

`ifdef CMLK_STAT_TIMESTAMP_EN
    logic [31:0] ts_cnt, ts_open;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ts_cnt  <= '0;
            ts_open <= '0;
        end else begin
            ts_cnt <= ts_cnt + 32'd1;
            if (cnt_load) ts_open <= ts_cnt;
        end
    end

    assign rec_d = {ft_prev, frame_idx, laser_cnt, gate_cnt, gate_on, ts_open};
`else
    assign rec_d = {ft_prev, frame_idx, laser_cnt, gate_cnt, gate_on};
`endif

    // frame_idx advances on every commit, even when the FIFO drops the record.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rec_q     <= '0;
            frame_idx <= '0;
        end else begin
            if (snap) rec_q <= rec_d;
            if (push) frame_idx <= frame_idx + 16'd1;
        end
    end

    // ---------------- record FIFO ----------------
    logic [REC_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic [LVL_W-1:0] level;
    logic             pop, full, wr_en, drop;

    assign stat_valid = (level != '0);
    assign pop        = stat_valid & stat_ready;
    assign full       = (level == FULL_LVL);
    assign wr_en      = push & (~full | pop);
    assign drop       = push & full & ~pop;
    assign stat_data  = mem[rd_ptr];
    assign fifo_level = level;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= rec_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + AW'(1);
            if (pop)   rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   level <= level + LVL_W'(1);
                2'b01:   level <= level - LVL_W'(1);
                default: level <= level;
            endcase
        end
    end

    // Clear has priority over a coincident drop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (stat_clear) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_cmlk_frame_stat_collector.sv
// Scoreboard bench for cmlk_frame_stat_collector. The stimulus generator derives each
// expected record from the frame it drives (rising-edge counts, high-cycle counts, frame
// index sequence) and queues it; an independent monitor pops and compares on each handshake.
module tb_cmlk_frame_stat_collector;

    localparam int DEPTH = 16;
    localparam int CW    = 8;
    localparam int MAXC  = (1 << CW) - 1;
`ifdef CMLK_STAT_TIMESTAMP_EN
    localparam int RW = 82 + 2 * CW;
`else
    localparam int RW = 50 + 2 * CW;
`endif

    typedef logic [RW-1:0] rec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          stat_en = 1'b0, stat_clear = 1'b0;
    logic          trig = 1'b0, laser = 1'b0, gate = 1'b0;
    logic [1:0]    ft = 2'b00;
    logic          ready = 1'b0;
    logic          stat_valid;
    logic [RW-1:0] stat_data;
    logic [4:0]    fifo_level;
    logic          overflow;
    logic [15:0]   drop_cnt;

    always #5 clk = ~clk;

    cmlk_frame_stat_collector #(
        .FIFO_DEPTH(DEPTH),
        .CNT_W     (CW)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .stat_en        (stat_en),
        .stat_clear     (stat_clear),
        .cmos_trig_pulse(trig),
        .laser_act      (laser),
        .gate_act       (gate),
        .frame_type     (ft),
        .stat_valid     (stat_valid),
        .stat_ready     (ready),
        .stat_data      (stat_data),
        .fifo_level     (fifo_level),
        .overflow       (overflow),
        .drop_cnt       (drop_cnt)
    );

    int   n_cmp = 0, n_bad = 0;
    rec_t sbq[$];

    // Reference model state
    logic        p_trig = 0, p_laser = 0, p_gate = 0;
    logic [1:0]  ft_last = 2'b00;
    logic        open = 0;
    int          acc_l, acc_g, acc_on;
    logic [15:0] m_idx = 16'd0;
    logic [31:0] m_ts = 0, m_ts_open = 0;
    int          ready_mode = 0;  // 0 always ready, 1 random, 2 stalled
    logic        ovf_mode = 0;
    int          exp_drop = 0;
    logic        exp_ovf = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic rec_t mk_rec();
`ifdef CMLK_STAT_TIMESTAMP_EN
        return {ft_last, m_idx, CW'(acc_l), CW'(acc_g), 32'(acc_on), m_ts_open};
`else
        return {ft_last, m_idx, CW'(acc_l), CW'(acc_g), 32'(acc_on)};
`endif
    endfunction

    // One clock cycle of stimulus, with the frame-level model updated from what is driven.
    task automatic cyc(input logic t, input logic l, input logic g, input logic [1:0] f);
        logic tr, lr, gr;
        trig = t; laser = l; gate = g; ft = f;
        case (ready_mode)
            0:       ready = 1'b1;
            1:       ready = (sbq.size() >= 8) ? 1'b1 : ($urandom_range(0, 1) == 1);
            default: ready = 1'b0;
        endcase
        tr = t & ~p_trig;
        lr = l & ~p_laser;
        gr = g & ~p_gate;
        if (stat_clear) begin
            exp_drop = 0;
            exp_ovf  = 0;
        end
        if (!stat_en) begin
            open = 0;
        end else if (tr) begin
            if (open) begin
                if (ovf_mode && sbq.size() >= DEPTH) begin
                    exp_drop++;
                    exp_ovf = 1;
                end else begin
                    sbq.push_back(mk_rec());
                end
                m_idx = m_idx + 16'd1;
            end
            open = 1;
            acc_l = int'(lr); acc_g = int'(gr); acc_on = int'(g);
            m_ts_open = m_ts;
        end else if (open) begin
            acc_l  = (acc_l + int'(lr) > MAXC) ? MAXC : acc_l + int'(lr);
            acc_g  = (acc_g + int'(gr) > MAXC) ? MAXC : acc_g + int'(gr);
            acc_on = acc_on + int'(g);
        end
        p_trig = t; p_laser = l; p_gate = g; ft_last = f;
        m_ts = m_ts + 32'd1;
        @(posedge clk);
        #1;
    endtask

    function automatic logic in_win(input int c, input int s, input int w);
        return (c >= s) && (c < s + w);
    endfunction

    // mode: 0 basic, 1 basic with laser edge on the trigger edge, 2 saturation,
    //       3 random, 4 short simple frame
    task automatic run_frame(input int len, input int th, input int mode,
                             input logic [1:0] f, input logic en_drop);
        logic lat;
        lat = open && (mode <= 1);
        for (int c = 0; c < len; c++) begin
            logic l, g;
            logic [1:0] ff;
            ff = f;
            l  = 1'b0;
            g  = 1'b0;
            case (mode)
                0, 1: begin
                    l = in_win(c, 100, 2) || in_win(c, 300, 2) || in_win(c, 500, 2) ||
                        in_win(c, 700, 2) || ((mode == 1) && in_win(c, 0, 2));
                    g = in_win(c, 150, 5) || in_win(c, 350, 5) || in_win(c, 550, 5) ||
                        in_win(c, 750, 5);
                end
                2: begin
                    l = (c >= 10) && (c < 610) && (c % 2 == 1);
                    g = in_win(c, 5, 66000);
                end
                3: begin
                    l  = ($urandom_range(0, 1) == 1);
                    g  = ($urandom_range(0, 2) != 0);
                    ff = 2'($urandom_range(0, 2));
                end
                default: begin
                    l = (c == 5);
                    g = in_win(c, 6, 3);
                end
            endcase
            if (en_drop && c == 5) stat_en = 1'b0;
            if (en_drop && c == 7) stat_en = 1'b1;
            cyc(c < th, l, g, ff);
            if (lat && c == 0) chk("valid low 1 cycle after edge", stat_valid, 0);
            if (lat && c == 1) chk("valid high 2 cycles after edge", stat_valid, 1);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sbq.size() != 0; i++) cyc(1'b0, 1'b0, 1'b0, 2'b00);
        chk("scoreboard drained", sbq.size(), 0);
        chk("level after drain", fifo_level, 0);
    endtask

    // Monitor: compares the FIFO head against the scoreboard on every accepted transfer.
    always @(negedge clk) begin : mon
        rec_t e;
        if (!rst && stat_valid && ready) begin
            if (sbq.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected record: got %0h expected none", stat_data);
            end else begin
                e = sbq.pop_front();
                chk("record", stat_data, e);
            end
        end
    end

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset valid", stat_valid, 0);
        chk("reset level", fifo_level, 0);
        chk("reset overflow", overflow, 0);
        chk("reset drop_cnt", drop_cnt, 0);
        stat_en = 1'b1;

        // Basic 1000-cycle frames: 4 laser pulses, 4 five-cycle gate pulses
        run_frame(1000, 3, 0, 2'b01, 1'b0);
        run_frame(1000, 3, 0, 2'b10, 1'b0);
        run_frame(1000, 3, 0, 2'b01, 1'b0);
        run_frame(1000, 3, 1, 2'b10, 1'b0);
        run_frame(1000, 3, 0, 2'b00, 1'b0);

        // Saturation: 300 laser pulses, gate held high for 66000 cycles
        run_frame(66010, 3, 2, 2'b01, 1'b0);

        // Random frames, random back-pressure, occasional enable drops
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            int len;
            logic dr;
            len = $urandom_range(3, 60);
            dr  = (i == 3 || i == 7 || $urandom_range(0, 5) == 0);
            if (dr && len < 10) len = 10;
            run_frame(len, $urandom_range(1, len - 1), 3, 2'b00, dr);
        end
        ready_mode = 0;
        drain();

        // Overflow: stalled sink, 20 frames into a 16-deep FIFO
        ready_mode = 2;
        ovf_mode   = 1;
        for (int i = 0; i < 20; i++) run_frame(20, 3, 4, 2'($urandom_range(0, 2)), 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'b00);
        chk("level full", fifo_level, DEPTH);
        chk("overflow set", overflow, exp_ovf);
        chk("drop_cnt", drop_cnt, exp_drop);
        stat_clear = 1'b1;
        cyc(1'b0, 1'b0, 1'b0, 2'b00);
        stat_clear = 1'b0;
        chk("overflow cleared", overflow, exp_ovf);
        chk("drop_cnt cleared", drop_cnt, exp_drop);

        // Clear coinciding with a drop (commit cycle)
        cyc(1'b1, 1'b0, 1'b0, 2'b01);
        stat_clear = 1'b1;
        cyc(1'b1, 1'b0, 1'b0, 2'b01);
        stat_clear = 1'b0;
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'b01);
        chk("clear beats drop: overflow", overflow, exp_ovf);
        chk("clear beats drop: drop_cnt", drop_cnt, exp_drop);
        run_frame(20, 3, 4, 2'b10, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'b00);
        chk("overflow after new drop", overflow, exp_ovf);
        chk("drop_cnt after new drop", drop_cnt, exp_drop);
        ovf_mode   = 0;
        ready_mode = 0;
        drain();

        // Reset with three records queued
        ready_mode = 2;
        for (int i = 0; i < 3; i++) run_frame(20, 3, 4, 2'b01, 1'b0);
        repeat (3) cyc(1'b0, 1'b0, 1'b0, 2'b00);
        chk("level before reset", fifo_level, 3);
        trig = 1'b0; laser = 1'b0; gate = 1'b0; ft = 2'b00;
        rst  = 1'b1;
        #1;
        chk("valid in reset", stat_valid, 0);
        chk("level in reset", fifo_level, 0);
        chk("overflow in reset", overflow, 0);
        sbq.delete();
        open = 0; m_idx = 16'd0; m_ts = 0; m_ts_open = 0;
        p_trig = 0; p_laser = 0; p_gate = 0; ft_last = 2'b00;
        exp_drop = 0; exp_ovf = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        ready_mode = 0;
        for (int i = 0; i < 4; i++) run_frame(25, 4, 4, 2'b10, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 2'b00);
        drain();
        chk("final overflow", overflow, exp_ovf);
        chk("final drop_cnt", drop_cnt, exp_drop);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
